exmem_skid_stage: RTL and testbench
===================================

EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of the address and data payload fields.
REQ-002 SHALL have parameter RADDR_W, default 5: width of the destination register index.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream offers a beat.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat this cycle.
REQ-008 SHALL have port in_ctrl  input  5  {mem_to_reg, reg_write, branch, mem_read, mem_write}.
REQ-009 SHALL have ports in_pc_branch, in_alu_result, in_rs2_data  input  XLEN each  payload data.
REQ-010 SHALL have port in_alu_zero  input  1  ALU zero flag.
REQ-011 SHALL have port in_rd  input  RADDR_W  destination register.
REQ-012 SHALL have port out_valid  output  1  stage presents a beat.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-014 SHALL have ports out_ctrl, out_pc_branch, out_alu_result, out_alu_zero, out_rs2_data, out_rd  output  widths as inputs  head-entry payload.
REQ-015 SHALL have port occupancy  output  2  held entries: 0, 1 or 2.

Function
REQ-016 SHALL hold up to two entries: main (head, drives outputs) and skid (second).
REQ-017 SHALL use three states: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
REQ-018 SHALL accept a beat when in_valid and in_ready are high; SHALL pop a beat when out_valid and out_ready are high.
REQ-019 SHALL drive in_ready = NOT skid-valid, taken from a register so that in_ready has no combinational path from out_ready.
REQ-020 SHALL present an accepted beat on the outputs one cycle after acceptance when the stage was EMPTY or popped in the same cycle.
REQ-021 EMPTY: push -> ONE, with main loaded.
REQ-022 ONE: push without pop -> FULL, with skid loaded; pop without push -> EMPTY; push and pop together -> ONE, with main replaced by the new beat.
REQ-023 FULL: pop -> ONE, with skid moved to main; in_valid is ignored because in_ready is low.
REQ-024 SHALL preserve strict FIFO order; no beat is dropped or duplicated without flush.
REQ-025 SHALL force out_ctrl to 0 whenever out_valid is low, so a bubble never writes memory or registers.
REQ-026 SHALL force the out_ctrl reg_write bit to 0 when out_rd == 0, even if the captured reg_write bit is 1.
REQ-027 SHALL store data fields unmodified at full XLEN width, with no truncation or extension.
REQ-028 flush SHALL clear both entries at the next edge (state -> EMPTY) and take priority over a simultaneous push or pop.
REQ-029 With flush high, in_valid in that cycle SHALL be discarded, and in_ready SHALL be high in the following cycle.
REQ-030 occupancy SHALL equal the state encoding (EMPTY 0, ONE 1, FULL 2).

Reset
REQ-031 While rst is high, state SHALL be EMPTY and out_valid = 0, in_ready = 1, occupancy = 0.
REQ-032 While rst is high, all out_* payload outputs and stored payload SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard all held entries immediately, without waiting for a clock edge.

Structure
REQ-034 The shared package SHALL define ctrl bit indices (CTRL_MEM_TO_REG=4 ... CTRL_MEM_WRITE=0), the state encoding, and the default XLEN and RADDR_W.
REQ-035 SHALL instantiate one sub-module, stage_entry_reg: a parametrised payload register with load enable and asynchronous clear, instantiated twice (main, skid).

Verification
REQ-036 Reset then idle: in_ready=1, out_valid=0, out_ctrl=0, occupancy=0.
REQ-037 Streaming with out_ready=1: push alu_result 0x10, 0x20, 0x30 on consecutive cycles -> same values on outputs one cycle later each, with in_ready always 1.
REQ-038 Backpressure: out_ready=0, push A=0xAAAA then B=0xBBBB -> occupancy=2 and in_ready=0; raise out_ready -> A popped, then B; occupancy returns to 0.
REQ-039 rd=0 with in_ctrl=5'b01000 -> out_ctrl=0 while out_valid=1; rd=3 with the same ctrl -> out_ctrl=5'b01000.
REQ-040 FULL plus flush asserted together with in_valid -> next cycle out_valid=0 and occupancy=0; the flushed-cycle beat never appears on the outputs.
REQ-041 rst pulsed asynchronously between edges while FULL -> out_valid drops immediately and payload outputs read 0.

Source files
------------

// File: rtl/exmem_skid_stage_pkg.sv
// Shared definitions for the EX/MEM skid-buffer pipeline stage:
// control-bit positions, state encoding and default widths.
package exmem_skid_stage_pkg;

  localparam int unsigned DEFAULT_XLEN    = 64;
  localparam int unsigned DEFAULT_RADDR_W = 5;
  localparam int unsigned CTRL_W          = 5;

  localparam int unsigned CTRL_MEM_TO_REG = 4;
  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 0;

  // Encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // A bubble must never write anything, and a write to x0 is meaningless
  function automatic logic [CTRL_W-1:0] gateCtrl(input logic [CTRL_W-1:0] ctrl,
                                                 input logic              valid,
                                                 input logic              rdIsZero);
    logic [CTRL_W-1:0] gated;
    gated = valid ? ctrl : '0;
    if (rdIsZero) begin
      gated[CTRL_REG_WRITE] = 1'b0;
    end
    return gated;
  endfunction

endpackage

// File: rtl/exmem_skid_stage_entry_reg.sv
// One payload slot of the skid stage: load-enabled register that is
// cleared asynchronously by reset.
module stage_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Capture the payload when loaded; reset wipes it immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer. The main entry
// drives the outputs; the skid entry catches one beat while downstream
// stalls so that in_ready can come straight from a register.
module exmem_skid_stage
  import exmem_skid_stage_pkg::*;
#(
  parameter int unsigned XLEN    = DEFAULT_XLEN,
  parameter int unsigned RADDR_W = DEFAULT_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [XLEN-1:0]    in_pc_branch,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic               in_alu_zero,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [XLEN-1:0]    out_pc_branch,
  output logic [XLEN-1:0]    out_alu_result,
  output logic               out_alu_zero,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic [1:0]         occupancy
);

  localparam int unsigned PAYLOAD_W = CTRL_W + 3 * XLEN + 1 + RADDR_W;

  stage_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0]  inPayload;
  logic [PAYLOAD_W-1:0]  mainPayload_d;
  logic [PAYLOAD_W-1:0]  mainPayload_q;
  logic [PAYLOAD_W-1:0]  skidPayload_q;
  logic [CTRL_W-1:0]     headCtrl;
  logic                  push;
  logic                  pop;
  logic                  loadMain;
  logic                  loadSkid;
  logic                  mainFromSkid;

  assign inPayload = {in_ctrl, in_pc_branch, in_alu_result, in_alu_zero, in_rs2_data, in_rd};

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State register; reset empties the stage without waiting for an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slot load controls; flush overrides any push or pop
  always_comb begin
    state_d      = state_q;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d  = ST_ONE;
            loadMain = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            loadMain = 1'b1;
          end else if (push) begin
            state_d  = ST_FULL;
            loadSkid = 1'b1;
          end else if (pop) begin
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d      = ST_ONE;
            loadMain     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign mainPayload_d = mainFromSkid ? skidPayload_q : inPayload;

  stage_entry_reg #(.W(PAYLOAD_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadMain),
    .d_i    (mainPayload_d),
    .q_o    (mainPayload_q)
  );

  stage_entry_reg #(.W(PAYLOAD_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (loadSkid),
    .d_i    (inPayload),
    .q_o    (skidPayload_q)
  );

  assign {headCtrl, out_pc_branch, out_alu_result, out_alu_zero, out_rs2_data, out_rd} = mainPayload_q;

  assign out_ctrl = gateCtrl(headCtrl, out_valid, (out_rd == '0));

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed self-checking bench for the EX/MEM skid stage.
module tb_exmem_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ctrl;
  logic [63:0] in_pc_branch;
  logic [63:0] in_alu_result;
  logic        in_alu_zero;
  logic [63:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_ctrl;
  logic [63:0] out_pc_branch;
  logic [63:0] out_alu_result;
  logic        out_alu_zero;
  logic [63:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;

  int compared   = 0;
  int mismatched = 0;

  exmem_skid_stage #(.XLEN(64), .RADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ctrl        (in_ctrl),
    .in_pc_branch   (in_pc_branch),
    .in_alu_result  (in_alu_result),
    .in_alu_zero    (in_alu_zero),
    .in_rs2_data    (in_rs2_data),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ctrl       (out_ctrl),
    .out_pc_branch  (out_pc_branch),
    .out_alu_result (out_alu_result),
    .out_alu_zero   (out_alu_zero),
    .out_rs2_data   (out_rs2_data),
    .out_rd         (out_rd),
    .occupancy      (occupancy)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Secondary payload fields are derived from alu so every beat is distinct
  task automatic applyStimulus(input logic valid, input logic [4:0] ctrl, input logic [63:0] alu,
                               input logic [4:0] rd, input logic ordy, input logic fl);
    in_valid      = valid;
    in_ctrl       = ctrl;
    in_alu_result = alu;
    in_pc_branch  = alu ^ 64'hF0F0_0000_0000_0000;
    in_rs2_data   = ~alu;
    in_alu_zero   = (alu == 64'd0);
    in_rd         = rd;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [63:0] alu, input logic [4:0] rd, input logic [4:0] ctrlExp);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".alu"}, out_alu_result, alu);
    checkOutput({tag, ".pc"}, out_pc_branch, alu ^ 64'hF0F0_0000_0000_0000);
    checkOutput({tag, ".rs2"}, out_rs2_data, ~alu);
    checkOutput({tag, ".zero"}, 64'(out_alu_zero), 64'(alu == 64'd0));
    checkOutput({tag, ".rd"}, 64'(out_rd), 64'(rd));
    checkOutput({tag, ".ctrl"}, 64'(out_ctrl), 64'(ctrlExp));
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, ".ctrl"}, 64'(out_ctrl), 64'd0);
    checkOutput({tag, ".occ"}, 64'(occupancy), 64'd0);
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Directed scenario sequence
  initial begin
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #2;
    checkEmpty("rst_async");
    checkOutput("rst_async.alu", out_alu_result, 64'd0);
    stepCycle();
    stepCycle();
    checkEmpty("rst_held");
    checkOutput("rst_held.pc", out_pc_branch, 64'd0);
    checkOutput("rst_held.rs2", out_rs2_data, 64'd0);
    checkOutput("rst_held.rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    checkEmpty("idle");

    // Streaming with downstream always ready
    applyStimulus(1'b1, 5'b01000, 64'h10, 5'd1, 1'b1, 1'b0);
    stepCycle();
    checkHead("s0", 64'h10, 5'd1, 5'b01000);
    checkOutput("s0.in_ready", 64'(in_ready), 64'd1);
    checkOutput("s0.occ", 64'(occupancy), 64'd1);
    applyStimulus(1'b1, 5'b01000, 64'h20, 5'd2, 1'b1, 1'b0);
    stepCycle();
    checkHead("s1", 64'h20, 5'd2, 5'b01000);
    checkOutput("s1.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 5'b01000, 64'h30, 5'd3, 1'b1, 1'b0);
    stepCycle();
    checkHead("s2", 64'h30, 5'd3, 5'b01000);
    checkOutput("s2.in_ready", 64'(in_ready), 64'd1);
    checkOutput("s2.occ", 64'(occupancy), 64'd1);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("s_drain");

    // Full-width payload held under stall
    applyStimulus(1'b1, 5'b11111, 64'hFFFF_0000_8000_0001, 5'd31, 1'b0, 1'b0);
    stepCycle();
    checkHead("wide", 64'hFFFF_0000_8000_0001, 5'd31, 5'b11111);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b0, 1'b0);
    stepCycle();
    checkHead("wide_hold", 64'hFFFF_0000_8000_0001, 5'd31, 5'b11111);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("wide_pop");

    // Backpressure fills both slots, then drains in order
    applyStimulus(1'b1, 5'b00001, 64'hAAAA, 5'd4, 1'b0, 1'b0);
    stepCycle();
    checkHead("bp_a", 64'hAAAA, 5'd4, 5'b00001);
    checkOutput("bp_a.occ", 64'(occupancy), 64'd1);
    checkOutput("bp_a.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 5'b00010, 64'hBBBB, 5'd5, 1'b0, 1'b0);
    stepCycle();
    checkHead("bp_full", 64'hAAAA, 5'd4, 5'b00001);
    checkOutput("bp_full.occ", 64'(occupancy), 64'd2);
    checkOutput("bp_full.in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 5'b00100, 64'hCCCC, 5'd6, 1'b1, 1'b0);
    stepCycle();
    checkHead("bp_b", 64'hBBBB, 5'd5, 5'b00010);
    checkOutput("bp_b.occ", 64'(occupancy), 64'd1);
    checkOutput("bp_b.in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("bp_drain");

    // reg_write suppressed for rd == 0
    applyStimulus(1'b1, 5'b01000, 64'h40, 5'd0, 1'b0, 1'b0);
    stepCycle();
    checkHead("rd0", 64'h40, 5'd0, 5'b00000);
    applyStimulus(1'b1, 5'b01000, 64'h50, 5'd3, 1'b1, 1'b0);
    stepCycle();
    checkHead("rd3", 64'h50, 5'd3, 5'b01000);
    checkOutput("rd3.occ", 64'(occupancy), 64'd1);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("rd_drain");

    // Flush from FULL with a concurrent push
    applyStimulus(1'b1, 5'b01001, 64'h60, 5'd7, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 5'b01010, 64'h70, 5'd8, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fl_pre.occ", 64'(occupancy), 64'd2);
    applyStimulus(1'b1, 5'b01000, 64'h77, 5'd9, 1'b1, 1'b1);
    stepCycle();
    checkEmpty("fl_post");
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("fl_quiet");
    applyStimulus(1'b1, 5'b01000, 64'h80, 5'd10, 1'b1, 1'b0);
    stepCycle();
    checkHead("fl_next", 64'h80, 5'd10, 5'b01000);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    stepCycle();
    checkEmpty("fl_drain");

    // Asynchronous reset between edges while FULL
    applyStimulus(1'b1, 5'b01000, 64'h90, 5'd11, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 5'b01000, 64'hA0, 5'd12, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ar_pre.occ", 64'(occupancy), 64'd2);
    applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkEmpty("ar");
    checkOutput("ar.alu", out_alu_result, 64'd0);
    checkOutput("ar.pc", out_pc_branch, 64'd0);
    checkOutput("ar.rs2", out_rs2_data, 64'd0);
    checkOutput("ar.rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    checkEmpty("ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
